fwd_stall_ctrl: RTL and testbench

Parametrised operand-forwarding and load-use stall controller for the rv32 pipeline. It sits beside the decode stage and compares the decode instruction's rs1/rs2 against the destinations of the instructions in the execute (EXE) and memory-access (ACC) stages. It selects forwarded operand values combinationally. A small state machine holds a stall for a configurable load latency, and a saturating counter records how many cycles were stalled.

---
 rtl/fwd_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_fwd_stall_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_stall_ctrl.sv
// Operand forwarding from EXE/ACC and load-use stall control for the rv32 decode stage.
// Forwarding and first stall cycle are combinational; HOLD extends the stall to LOAD_LAT cycles.
module fwd_stall_ctrl #(
  parameter int XLEN     = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_de,
  input  logic             de_valid,
  input  logic [31:0]      instr_exe,
  input  logic             exe_valid,
  input  logic [XLEN-1:0]  alu_out_exe,
  input  logic [XLEN-1:0]  pc_exe,
  input  logic [31:0]      instr_acc,
  input  logic             acc_valid,
  input  logic [XLEN-1:0]  alu_out_acc,
  input  logic [XLEN-1:0]  dmem_out_acc,
  input  logic [XLEN-1:0]  pc_4_acc,
  output logic             stall,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic [XLEN-1:0]  data_a_mgr,
  output logic [XLEN-1:0]  data_b_mgr,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {W_NONE, W_ALU, W_LINK, W_LOAD} wr_t;
  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [1:0] HOLD_INIT = 2'(LOAD_LAT - 1);

  function automatic wr_t classify(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: classify = W_ALU;
      7'b1101111, 7'b1100111:                         classify = W_LINK;
      7'b0000011:                                     classify = W_LOAD;
      default:                                        classify = W_NONE;
    endcase
  endfunction

  logic [4:0]      rs1, rs2, rd_exe, rd_acc;
  wr_t             kind_exe, kind_acc;
  logic            exe_wr, acc_wr, exe_a, exe_b, acc_a, acc_b, exe_load, load_use;
  logic [XLEN-1:0] exe_val, acc_val;
  state_t          state, state_nxt;
  logic [1:0]      cnt, cnt_nxt;
  logic            unused_bits;

  assign rs1      = instr_de[19:15];
  assign rs2      = instr_de[24:20];
  assign rd_exe   = instr_exe[11:7];
  assign rd_acc   = instr_acc[11:7];
  assign kind_exe = classify(instr_exe[6:0]);
  assign kind_acc = classify(instr_acc[6:0]);

  assign exe_wr   = de_valid && exe_valid && (kind_exe != W_NONE) && (rd_exe != 5'd0);
  assign acc_wr   = de_valid && acc_valid && (kind_acc != W_NONE) && (rd_acc != 5'd0);
  assign exe_a    = exe_wr && (rd_exe == rs1);
  assign exe_b    = exe_wr && (rd_exe == rs2);
  assign acc_a    = acc_wr && (rd_acc == rs1);
  assign acc_b    = acc_wr && (rd_acc == rs2);
  assign exe_load = (kind_exe == W_LOAD);
  assign load_use = (exe_a || exe_b) && exe_load;

  assign exe_val  = (kind_exe == W_LINK) ? pc_exe + XLEN'(4) : alu_out_exe;

  always_comb begin
    acc_val = alu_out_acc;
    case (kind_acc)
      W_LINK:  acc_val = pc_4_acc;
      W_LOAD:  acc_val = dmem_out_acc;
      default: acc_val = alu_out_acc;
    endcase
  end

  // An EXE load match blocks the operand entirely, so an older ACC value cannot leak through.
  always_comb begin
    hazard_a   = 1'b0;
    hazard_b   = 1'b0;
    data_a_mgr = '0;
    data_b_mgr = '0;
    if (!rst) begin
      if (exe_a) begin
        if (!exe_load) begin
          hazard_a   = 1'b1;
          data_a_mgr = exe_val;
        end
      end else if (acc_a) begin
        hazard_a   = 1'b1;
        data_a_mgr = acc_val;
      end
      if (exe_b) begin
        if (!exe_load) begin
          hazard_b   = 1'b1;
          data_b_mgr = exe_val;
        end
      end else if (acc_b) begin
        hazard_b   = 1'b1;
        data_b_mgr = acc_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = load_use;
        if (load_use && (LOAD_LAT > 1)) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_INIT;
        end
      end
      HOLD: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign unused_bits = ^{instr_de[31:25], instr_de[14:0], instr_exe[31:12], instr_acc[31:12]};

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Bench for fwd_stall_ctrl: three instances (LOAD_LAT 1/3/2, last with CNT_W=4) share the stimulus.
module tb_fwd_stall_ctrl;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_IMM = 7'b0010011,
                         OP_OP = 7'b0110011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_LOAD = 7'b0000011, OP_BR = 7'b1100011, OP_ST = 7'b0100011,
                         OP_SYS = 7'b1110011, OP_UNK = 7'b0101011;
  localparam int LATS [3] = '{1, 3, 2};
  localparam int MAXC [3] = '{65535, 65535, 15};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_de, instr_exe, instr_acc;
  logic        de_valid, exe_valid, acc_valid;
  logic [31:0] alu_out_exe, pc_exe, alu_out_acc, dmem_out_acc, pc_4_acc;

  logic [2:0]  stall_v, hza_v, hzb_v;
  logic [31:0] da_v [3];
  logic [31:0] db_v [3];
  logic [15:0] sc_v [3];

  int nvec = 0;
  int nerr = 0;
  bit armed = 1'b0;
  int rem [3] = '{0, 0, 0};
  int scnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 4 : 16;
    logic [CW-1:0] sc;
    fwd_stall_ctrl #(.XLEN(32), .LOAD_LAT(LATS[g]), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst),
      .instr_de(instr_de), .de_valid(de_valid),
      .instr_exe(instr_exe), .exe_valid(exe_valid),
      .alu_out_exe(alu_out_exe), .pc_exe(pc_exe),
      .instr_acc(instr_acc), .acc_valid(acc_valid),
      .alu_out_acc(alu_out_acc), .dmem_out_acc(dmem_out_acc), .pc_4_acc(pc_4_acc),
      .stall(stall_v[g]), .hazard_a(hza_v[g]), .hazard_b(hzb_v[g]),
      .data_a_mgr(da_v[g]), .data_b_mgr(db_v[g]), .stall_cnt(sc)
    );
    assign sc_v[g] = 16'(sc);
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] s1, input logic [4:0] s2);
    return {7'd0, s2, s1, 3'd0, rd, op};
  endfunction

  // 0 none, 1 alu result, 2 link value, 3 load data
  function automatic int kind(input logic [31:0] ins);
    case (ins[6:0])
      OP_LUI, OP_AUIPC, OP_IMM, OP_OP: return 1;
      OP_JAL, OP_JALR:                 return 2;
      OP_LOAD:                         return 3;
      default:                         return 0;
    endcase
  endfunction

  function automatic bit writes(input bit vld, input logic [31:0] ins, input logic [4:0] src);
    return de_valid && vld && kind(ins) != 0 && ins[11:7] != 5'd0 && ins[11:7] == src;
  endfunction

  function automatic void fwd_model(input logic [4:0] src, output logic hz, output logic [31:0] v);
    hz = 1'b0;
    v  = 32'd0;
    if (rst) return;
    if (writes(exe_valid, instr_exe, src)) begin
      if (kind(instr_exe) == 3) return;
      hz = 1'b1;
      v  = (kind(instr_exe) == 2) ? pc_exe + 32'd4 : alu_out_exe;
    end else if (writes(acc_valid, instr_acc, src)) begin
      hz = 1'b1;
      case (kind(instr_acc))
        2:       v = pc_4_acc;
        3:       v = dmem_out_acc;
        default: v = alu_out_acc;
      endcase
    end
  endfunction

  function automatic bit luse_model();
    return kind(instr_exe) == 3 &&
           (writes(exe_valid, instr_exe, instr_de[19:15]) || writes(exe_valid, instr_exe, instr_de[24:20]));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: stall cycles still owed after the current one, and saturating stall count.
  always @(posedge clk) begin
    bit lu;
    lu = luse_model();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rem[i]  = 0;
        scnt[i] = 0;
      end else begin
        if ((rem[i] > 0 || lu) && scnt[i] < MAXC[i]) scnt[i]++;
        if (rem[i] > 0) rem[i]--;
        else if (lu) rem[i] = LATS[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    logic ha, hb, st;
    logic [31:0] va, vb;
    if (armed) begin
      fwd_model(instr_de[19:15], ha, va);
      fwd_model(instr_de[24:20], hb, vb);
      for (int i = 0; i < 3; i++) begin
        st = !rst && (rem[i] > 0 || luse_model());
        chk($sformatf("u%0d stall", i), 32'(stall_v[i]), 32'(st));
        chk($sformatf("u%0d hazard_a", i), 32'(hza_v[i]), 32'(ha));
        chk($sformatf("u%0d hazard_b", i), 32'(hzb_v[i]), 32'(hb));
        chk($sformatf("u%0d data_a", i), da_v[i], va);
        chk($sformatf("u%0d data_b", i), db_v[i], vb);
        chk($sformatf("u%0d stall_cnt", i), 32'(sc_v[i]), 32'(scnt[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    de_valid = 0; exe_valid = 0; acc_valid = 0;
    instr_de = 0; instr_exe = 0; instr_acc = 0;
    alu_out_exe = 0; pc_exe = 0; alu_out_acc = 0; dmem_out_acc = 0; pc_4_acc = 0;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk({"lit ", name}, act, exp);
  endtask

  initial begin
    logic [6:0] ops [11];
    ops = '{OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_JAL, OP_JALR, OP_LOAD, OP_BR, OP_ST, OP_SYS, OP_UNK};
    rst = 1'b1;
    set_idle();
    // Hazard-producing inputs held during reset must stay masked.
    de_valid = 1; instr_de = mk(OP_OP, 7, 5, 3);
    exe_valid = 1; instr_exe = mk(OP_IMM, 5, 0, 0); alu_out_exe = 32'h11;
    acc_valid = 1; instr_acc = mk(OP_LOAD, 3, 0, 0);
    @(negedge clk);
    lit("rst hazard_a", 32'(hza_v), 32'd0);
    lit("rst data_a", da_v[0], 32'd0);
    tick();
    armed = 1'b1;
    instr_exe = mk(OP_LOAD, 5, 0, 0);
    @(negedge clk);
    lit("rst stall", 32'(stall_v), 32'd0);
    tick();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    lit("post-rst stall_cnt", 32'(sc_v[1]), 32'd0);
    tick();

    // ALU forwarding, EXE beats ACC
    de_valid = 1; instr_de = mk(OP_OP, 7, 5, 5);
    exe_valid = 1; instr_exe = mk(OP_IMM, 5, 0, 0); alu_out_exe = 32'h11;
    acc_valid = 1; instr_acc = mk(OP_OP, 5, 6, 0); alu_out_acc = 32'h22;
    @(negedge clk);
    lit("alu hazards", {hza_v[0], hzb_v[0]}, 32'd3);
    lit("alu data_a", da_v[0], 32'h11);
    lit("alu data_b", db_v[0], 32'h11);
    lit("alu stall", 32'(stall_v[0]), 32'd0);
    tick();

    set_idle();
    de_valid = 1; instr_de = mk(OP_OP, 7, 0, 6);
    exe_valid = 1; instr_exe = mk(OP_IMM, 0, 0, 0); alu_out_exe = 32'hFF;
    @(negedge clk);
    lit("x0 hazard_a", 32'(hza_v[0]), 32'd0);
    lit("x0 data_a", da_v[0], 32'd0);
    tick();

    set_idle();
    de_valid = 1; instr_de = mk(OP_OP, 7, 2, 1);
    exe_valid = 1; instr_exe = mk(OP_JAL, 1, 0, 0); pc_exe = 32'h100;
    @(negedge clk);
    lit("jal exe hazard_b", 32'(hzb_v[0]), 32'd1);
    lit("jal exe data_b", db_v[0], 32'h104);
    tick();
    exe_valid = 0;
    acc_valid = 1; instr_acc = mk(OP_JAL, 1, 0, 0); pc_4_acc = 32'h204;
    @(negedge clk);
    lit("jal acc data_b", db_v[0], 32'h204);
    tick();

    // Load-use: the ACC writer of x3 must be suppressed in the detect cycle
    set_idle();
    de_valid = 1; instr_de = mk(OP_OP, 7, 3, 0);
    exe_valid = 1; instr_exe = mk(OP_LOAD, 3, 0, 0);
    acc_valid = 1; instr_acc = mk(OP_IMM, 3, 0, 0); alu_out_acc = 32'h55;
    @(negedge clk);
    lit("ld detect stall", 32'(stall_v), 32'd7);
    lit("ld detect hazard_a", 32'(hza_v), 32'd0);
    tick();
    exe_valid = 0; instr_exe = 0;
    instr_acc = mk(OP_LOAD, 3, 0, 0); dmem_out_acc = 32'hDEAD;
    @(negedge clk);
    lit("lat1 stall drop", 32'(stall_v[0]), 32'd0);
    lit("lat1 hazard_a", 32'(hza_v[0]), 32'd1);
    lit("lat1 data_a", da_v[0], 32'hDEAD);
    lit("lat1 stall_cnt", 32'(sc_v[0]), 32'd1);
    lit("lat3 hold stall", 32'(stall_v[1]), 32'd1);
    lit("lat3 hold data_a", da_v[1], 32'hDEAD);
    tick();
    @(negedge clk);
    lit("lat3 third stall", 32'(stall_v[1]), 32'd1);
    lit("lat2 stall drop", 32'(stall_v[2]), 32'd0);
    tick();
    @(negedge clk);
    lit("lat3 stall drop", 32'(stall_v[1]), 32'd0);
    lit("lat3 stall_cnt", 32'(sc_v[1]), 32'd3);
    tick();

    // Reset in the second stall cycle of LOAD_LAT=3
    set_idle();
    de_valid = 1; instr_de = mk(OP_OP, 7, 0, 3);
    exe_valid = 1; instr_exe = mk(OP_LOAD, 3, 0, 0);
    tick();
    exe_valid = 0; instr_exe = 0;
    rst = 1'b1;
    @(negedge clk);
    lit("rst mid-hold stall", 32'(stall_v[1]), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    lit("after rst stall", 32'(stall_v[1]), 32'd0);
    lit("after rst stall_cnt", 32'(sc_v[1]), 32'd0);
    tick();

    // Non-writers in EXE whose rd field aliases rs1
    set_idle();
    de_valid = 1; instr_de = mk(OP_OP, 7, 9, 0);
    exe_valid = 1; instr_exe = mk(OP_BR, 9, 0, 0); alu_out_exe = 32'h77;
    @(negedge clk);
    lit("branch hazard_a", 32'(hza_v[0]), 32'd0);
    lit("branch stall", 32'(stall_v[0]), 32'd0);
    tick();
    instr_exe = mk(OP_ST, 9, 0, 0);
    @(negedge clk);
    lit("store hazard_a", 32'(hza_v[0]), 32'd0);
    tick();

    // 20 back-to-back stall cycles
    set_idle();
    de_valid = 1; instr_de = mk(OP_OP, 7, 3, 3);
    exe_valid = 1; instr_exe = mk(OP_LOAD, 3, 0, 0);
    repeat (20) tick();
    set_idle();
    @(negedge clk);
    lit("sat stall_cnt", 32'(sc_v[2]), 32'd15);
    lit("wide stall_cnt", 32'(sc_v[0]), 32'd20);
    repeat (4) tick();

    // Classification sweep, ACC provides a fallback writer of the same register
    for (int k = 0; k < 11; k++) begin
      set_idle();
      de_valid = 1; instr_de = mk(OP_OP, 7, 9, 9);
      exe_valid = 1; instr_exe = mk(ops[k], 9, 1, 2);
      alu_out_exe = 32'h1000 + 32'(k); pc_exe = 32'h300;
      acc_valid = 1; instr_acc = mk(OP_OP, 9, 0, 0); alu_out_acc = 32'hAA;
      tick();
      set_idle();
      repeat (3) tick();
    end

    @(negedge clk);
    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
